serial_add_ctrl: RTL and testbench

- Digit-serial multi-precision adder/subtractor controller.
- Sequences one 4-bit ripple slice, the existing fa_4bit, over WIDTH/4 cycles to add or subtract two WIDTH-bit operands.
- Carry is held in a register between slices.
- Valid/ready handshakes on both input and result side; sits between a requesting unit and any consumer of wide sums where area is preferred over latency.

---
 rtl/serial_add_ctrl.sv | 173 +++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Purpose : digit-serial WIDTH-bit add/subtract, one 4-bit ripple slice per cycle.
// Latency : out_valid rises N = WIDTH/4 cycles after the accepting edge.
// Backpr. : result held in DONE until out_ready; in_ready stays low from accept through handshake.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (op_a, op_b, op_sub)
//   out_valid/out_ready  result handshake (result, cout, ovf)
//   busy                 high while an operation is in RUN or DONE

// 4-bit ripple slice: sum and carry of a + b + cin.
module fa_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [3:0] sl_a, sl_b, sl_sum;
  logic       sl_co;

  // Slice k covers bits [4k+3:4k]; {k,2'b00} is 4k.
  assign sl_a = a_q[{k_q, 2'b00} +: 4];
  assign sl_b = b_q[{k_q, 2'b00} +: 4];

  fa_4bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_co)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    k_d         = k_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtract is A + ~B + 1: invert B here, seed the carry with 1.
          a_d         = op_a;
          b_d         = op_sub ? ~op_b : op_b;
          carry_d     = op_sub;
          k_d         = '0;
          result_d    = '0;
          cout_d      = 1'b0;
          ovf_d       = 1'b0;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = RUN;
        end
      end

      RUN: begin
        result_d[{k_q, 2'b00} +: 4] = sl_sum;
        carry_d = sl_co;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d         = '0;
          cout_d      = sl_co;
          // Overflow: operands share a sign the new MSB does not.
          ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[3] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          // in_ready rises at this edge, so it is never high alongside out_valid.
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Purpose : self-checking bench for serial_add_ctrl (WIDTH = 16).
// Latency : checks out_valid rising exactly 4 cycles after accept.
// Backpr. : exercises held and random out_ready against a reference model.
module tb_serial_add_ctrl;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 result presented.
  int           m_ph  = 0;
  int           m_sl  = 0;
  bit           m_clr = 1'b1;
  logic [W-1:0] m_res = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W:0]   m_s17;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph  = 0;
      m_sl  = 0;
      m_clr = 1'b1;
    end else begin
      case (m_ph)
        0: if (in_valid) begin
          if (op_sub) begin
            m_res  = op_a - op_b;
            m_cout = (op_a >= op_b);
            m_ovf  = (op_a[W-1] != op_b[W-1]) && (m_res[W-1] != op_a[W-1]);
          end else begin
            m_s17  = {1'b0, op_a} + {1'b0, op_b};
            m_res  = m_s17[W-1:0];
            m_cout = m_s17[W];
            m_ovf  = (op_a[W-1] == op_b[W-1]) && (m_res[W-1] != op_a[W-1]);
          end
          m_sl  = 0;
          m_clr = 1'b0;
          m_ph  = 1;
        end
        1: begin
          m_sl++;
          if (m_sl == N) m_ph = 2;
        end
        default: if (out_ready) begin
          m_ph = 0;
          n_done++;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic [31:0] mk;
    #3;
    forever begin
      @(negedge clk);
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_ph == 0});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_ph == 2});
      chk("busy", {31'b0, busy}, {31'b0, m_ph != 0});
      if (m_ph == 2) begin
        chk("result", {16'b0, result}, {16'b0, m_res});
        chk("cout", {31'b0, cout}, {31'b0, m_cout});
        chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
      end else if (m_ph == 1) begin
        mk = (32'h1 << (4 * m_sl)) - 32'h1;
        chk("partial_result", {16'b0, result}, {16'b0, m_res} & mk);
      end else if (m_clr) begin
        chk("idle_result", {16'b0, result}, 32'h0);
        chk("idle_cout", {31'b0, cout}, 32'h0);
        chk("idle_ovf", {31'b0, ovf}, 32'h0);
      end
    end
  end

  // One directed operation with hand-computed expectations.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input int hold, input bit keep);
    int i;
    int lat;
    out_ready = (hold == 0);
    i = 0;
    while (!in_ready && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    chk("wait_in_ready", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = s;
    @(posedge clk); #1;
    in_valid = keep;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
    op_sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 50) begin
      chk("in_ready_low_run", {31'b0, in_ready}, 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, N);
    chk("lit_result", {16'b0, result}, {16'b0, er});
    chk("lit_cout", {31'b0, cout}, {31'b0, ec});
    chk("lit_ovf", {31'b0, ovf}, {31'b0, eo});
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk("hold_valid", {31'b0, out_valid}, 32'h1);
      chk("hold_result", {16'b0, result}, {16'b0, er});
      chk("hold_in_ready", {31'b0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("post_in_ready", {31'b0, in_ready}, 32'h1);
    chk("post_out_valid", {31'b0, out_valid}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] pick [4];
    pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h8000; pick[3] = 16'h7FFF;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_result", {16'b0, result}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b1);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    do_op(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 10, 1'b0);

    // Reset after two slices have been processed.
    in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h1111; op_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_result", {16'b0, result}, 32'h0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

    // Random traffic with random backpressure; the model checks every cycle.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      op_a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      op_b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      op_sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("progress", {31'b0, n_done > 50}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
